// File: rtl/divmod_pkg.sv
// rtl/divmod_pkg.sv - shared state encoding and constants for the divmod arbiter
package divmod_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] DZ_QUOTIENT = 8'hFF;
  localparam int         CYC_W       = 9;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Grants the first set req bit searching upward from ptr+1, wrapping modulo N.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] gnt_id
);

  logic [IDW-1:0] idx;

  // Scan from the farthest candidate down so the nearest one after ptr wins.
  always_comb begin
    any    = 1'b0;
    gnt_id = '0;
    idx    = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IDW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        any    = 1'b1;
        gnt_id = idx;
      end
    end
  end

endmodule

// File: rtl/divmod_arbiter.sv
// rtl/divmod_arbiter.sv - round-robin sharing of one external 8-bit divmod unit
// Divide-by-zero requests are answered locally without touching the divider.
module divmod_arbiter
  import divmod_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [8*N-1:0]   req_dividend,
  input  logic [8*N-1:0]   req_divisor,
  output logic [N-1:0]     done,
  output logic             res_valid,
  output logic [IDW-1:0]   res_id,
  output logic [7:0]       res_quotient,
  output logic [7:0]       res_remainder,
  output logic             res_dz,
  output logic [8:0]       res_cycles,
  output logic             div_valid,
  output logic [7:0]       div_dividend,
  output logic [7:0]       div_divisor,
  input  logic             div_ready,
  input  logic [7:0]       div_quotient,
  input  logic [7:0]       div_remainder
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   id;
  logic [CYC_W-1:0] cnt;
  logic [CYC_W-1:0] cnt_inc;
  logic             any;
  logic [IDW-1:0]   gnt_id;
  logic [7:0]       sel_dividend;
  logic [7:0]       sel_divisor;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (any),
    .gnt_id (gnt_id)
  );

  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_dividend = req_dividend[8*i +: 8];
        sel_divisor  = req_divisor[8*i +: 8];
      end
    end
  end

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= IDW'(N - 1);
      id            <= '0;
      cnt           <= '0;
      done          <= '0;
      res_valid     <= 1'b0;
      res_id        <= '0;
      res_quotient  <= '0;
      res_remainder <= '0;
      res_dz        <= 1'b0;
      res_cycles    <= '0;
      div_valid     <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
    end else begin
      done      <= '0;
      res_valid <= 1'b0;
      div_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            id           <= gnt_id;
            div_dividend <= sel_dividend;
            div_divisor  <= sel_divisor;
            if (sel_divisor == 8'd0) begin
              state         <= DONE;
              done          <= ONE << gnt_id;
              res_valid     <= 1'b1;
              res_id        <= gnt_id;
              res_quotient  <= DZ_QUOTIENT;
              res_remainder <= sel_dividend;
              res_dz        <= 1'b1;
              res_cycles    <= '0;
            end else begin
              state     <= ISSUE;
              div_valid <= 1'b1;
            end
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt_inc;
          if (div_ready) begin
            state         <= DONE;
            done          <= ONE << id;
            res_valid     <= 1'b1;
            res_id        <= id;
            res_quotient  <= div_quotient;
            res_remainder <= div_remainder;
            res_dz        <= 1'b0;
            res_cycles    <= cnt_inc;
          end
        end
        DONE: begin
          ptr   <= id;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Client and divider protocol checks; violations are flagged, not corrected.
  a_ready_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    div_ready |-> state == WAIT);

  for (genvar g = 0; g < N; g++) begin : g_req_chk
    a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
      $fell(req[g]) |-> $past(done[g]));
  end

endmodule

// File: tb/tb_divmod_arbiter.sv
// tb/tb_divmod_arbiter.sv - scoreboard bench for divmod_arbiter
module tb_divmod_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_dividend, req_divisor;
  logic [N-1:0]   done;
  logic           res_valid, res_dz, div_valid, div_ready;
  logic [IDW-1:0] res_id;
  logic [7:0]     res_quotient, res_remainder, div_dividend, div_divisor;
  logic [7:0]     div_quotient, div_remainder;
  logic [8:0]     res_cycles;

  always #5 clk = ~clk;

  divmod_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .done(done), .res_valid(res_valid), .res_id(res_id),
    .res_quotient(res_quotient), .res_remainder(res_remainder),
    .res_dz(res_dz), .res_cycles(res_cycles),
    .div_valid(div_valid), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_ready(div_ready), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  typedef struct { int id; int dvd; int dvs; int gcyc; } exp_t;
  typedef struct { int id; int dvd; int dvs; } job_t;

  int   compared = 0;
  int   mismatched = 0;
  exp_t sb_q[$];
  exp_t iss_q[$];
  int   wait_q[$];
  job_t jobs[$];
  int   served_q[$];
  int   neg_cnt = 0;
  int   model_ptr = N - 1;
  bit   model_free = 1'b1;
  int   force_lat = -1;
  int   epoch = 0;
  logic [7:0] last_q = '0, last_r = '0;
  logic       last_dz = 1'b0;
  logic [8:0] last_cyc = '0;
  int         last_id = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: got event expected none", name);
  endtask

  function automatic int rr_next(input int p, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic add_job(input int id, input int dvd, input int dvs);
    job_t j;
    j.id = id; j.dvd = dvd; j.dvs = dvs;
    jobs.push_back(j);
  endtask

  // Requesters: drop req after the edge that samples done, then take the next queued job.
  initial begin
    logic [N-1:0] d;
    req = '0; req_dividend = '0; req_divisor = '0;
    forever begin
      @(negedge clk);
      d = done;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (d[i]) req[i] = 1'b0;
        if (!req[i]) begin
          for (int j = 0; j < jobs.size(); j++) begin
            if (jobs[j].id == i) begin
              req_dividend[8*i +: 8] = 8'(jobs[j].dvd);
              req_divisor[8*i +: 8]  = 8'(jobs[j].dvs);
              req[i] = 1'b1;
              jobs.delete(j);
              break;
            end
          end
        end
      end
    end
  end

  // Divider model: answers each start after a chosen number of WAIT cycles.
  initial begin
    int   l, ep;
    exp_t e;
    div_ready = 1'b0; div_quotient = '0; div_remainder = '0;
    forever begin
      @(negedge clk);
      if (rst_n && div_valid) begin
        ep = epoch;
        if (iss_q.size() == 0) begin
          flag("unexpected_div_valid");
          e.dvd = 0; e.dvs = 1;
        end else begin
          e = iss_q.pop_front();
          check("div_dividend", div_dividend, e.dvd);
          check("div_divisor", div_divisor, e.dvs);
        end
        l = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 6));
        wait_q.push_back(l + 1);
        for (int k = 0; k <= l; k++) begin
          @(posedge clk);
          if (epoch != ep) break;
        end
        #1;
        if (epoch == ep) begin
          div_ready     = 1'b1;
          div_quotient  = 8'(e.dvd / e.dvs);
          div_remainder = 8'(e.dvd % e.dvs);
          @(posedge clk);
          #1;
          div_ready = 1'b0;
        end
      end
    end
  end

  // Monitor: predicts grants from the round-robin rule and scores every result.
  always @(negedge clk) begin
    exp_t e;
    int   g, w, eq, er;
    neg_cnt++;
    if (!rst_n) begin
      sb_q.delete(); iss_q.delete(); wait_q.delete();
      model_ptr = N - 1; model_free = 1'b1;
      last_q = '0; last_r = '0; last_dz = 1'b0; last_cyc = '0; last_id = 0;
    end else begin
      if (model_free && req != '0) begin
        g = rr_next(model_ptr, req);
        e.id = g; e.dvd = int'(req_dividend[8*g +: 8]); e.dvs = int'(req_divisor[8*g +: 8]);
        e.gcyc = neg_cnt;
        sb_q.push_back(e);
        if (e.dvs != 0) iss_q.push_back(e);
        model_free = 1'b0;
      end
      if (res_valid) begin
        if (sb_q.size() == 0) begin
          flag("unexpected_res_valid");
        end else begin
          e = sb_q.pop_front();
          eq = (e.dvs == 0) ? 255 : e.dvd / e.dvs;
          er = (e.dvs == 0) ? e.dvd : e.dvd % e.dvs;
          w = 0;
          if (e.dvs != 0) begin
            if (wait_q.size() == 0) flag("missing_divider_reply");
            else w = wait_q.pop_front();
          end
          check("res_id", res_id, e.id);
          check("done_onehot", done, 1 << e.id);
          check("res_quotient", res_quotient, eq);
          check("res_remainder", res_remainder, er);
          check("res_dz", res_dz, e.dvs == 0);
          check("res_cycles", res_cycles, (w > 511) ? 511 : w);
          check("latency", neg_cnt - e.gcyc, (e.dvs == 0) ? 1 : w + 2);
          served_q.push_back(e.id);
          model_ptr = e.id;
          model_free = 1'b1;
          last_q = 8'(eq); last_r = 8'(er); last_dz = (e.dvs == 0);
          last_cyc = 9'((w > 511) ? 511 : w); last_id = e.id;
        end
      end else begin
        check("done_idle", done, 0);
        check("hold_quotient", res_quotient, last_q);
        check("hold_remainder", res_remainder, last_r);
        check("hold_dz", res_dz, last_dz);
        check("hold_cycles", res_cycles, last_cyc);
        check("hold_id", res_id, last_id);
      end
    end
  end

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((jobs.size() != 0 || req != '0 || sb_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) flag({name, "_timeout"});
    repeat (2) @(posedge clk);
  endtask

  task automatic check_order(input string name, input int exp[$]);
    check({name, "_count"}, served_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < served_q.size(); i++)
      check({name, "_order"}, served_q[i], exp[i]);
    served_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_done"}, done, 0);
    check({name, "_res_valid"}, res_valid, 0);
    check({name, "_res_id"}, res_id, 0);
    check({name, "_res_quotient"}, res_quotient, 0);
    check({name, "_res_remainder"}, res_remainder, 0);
    check({name, "_res_dz"}, res_dz, 0);
    check({name, "_res_cycles"}, res_cycles, 0);
    check({name, "_div_valid"}, div_valid, 0);
    check({name, "_div_dividend"}, div_dividend, 0);
    check({name, "_div_divisor"}, div_divisor, 0);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    rst_n = 1'b1;

    add_job(0, 100, 7);
    drain("single");
    check_order("single", '{0});
    check("single_q", res_quotient, 14);
    check("single_r", res_remainder, 2);

    add_job(2, 55, 0);
    drain("divzero");
    check_order("divzero", '{2});

    add_job(1, 17, 4); add_job(3, 90, 11);
    drain("wrap");
    check_order("wrap", '{3, 1});

    add_job(3, 5, 2);
    drain("prep");
    served_q.delete();
    add_job(0, 250, 13); add_job(1, 77, 77); add_job(2, 3, 9); add_job(3, 128, 0);
    add_job(0, 201, 10);
    drain("all_four");
    check_order("all_four", '{0, 1, 2, 3, 0});

    add_job(1, 200, 3); add_job(1, 9, 9);
    drain("back_to_back");
    check_order("back_to_back", '{1, 1});

    force_lat = 40;
    add_job(1, 61, 5); add_job(3, 222, 7);
    t = 0;
    while (!div_valid && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) flag("reset_wait_timeout");
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    epoch++;
    #1;
    check_all_zero("async_reset");
    served_q.delete();
    force_lat = -1;
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    drain("after_reset");
    check_order("after_reset", '{1, 3});

    force_lat = 520;
    add_job(2, 250, 17);
    drain("saturate");
    force_lat = -1;
    served_q.delete();

    for (int i = 0; i < 40; i++) begin
      add_job(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)),
              ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain("random");
    check("random_served", served_q.size(), 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/divmod_arbiter.md
Name: divmod_arbiter

Overview:
- Round-robin controller that shares one 8-bit divmod unit between N requesters.
- Selects a requester, issues its operands to the divider with a valid pulse, waits for the divider's ready pulse, then returns quotient and remainder to that requester.
- Handles divide-by-zero locally without using the divider.
- Sits between client blocks and the single divmod instance at the same hierarchy level. The divider is external to this block.

Parameters:
- N, 4, number of requesters (2..8)
- IDW, 2, requester-id width; must equal ceil(log2(N))

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N  per-requester request level
- req_dividend  input  8*N  dividend of requester i on bits [8i+7:8i]
- req_divisor  input  8*N  divisor of requester i on bits [8i+7:8i]
- done  output  N  one-hot, one-cycle completion pulse to the served requester
- res_valid  output  1  one-cycle result strobe, coincident with done
- res_id  output  IDW  id of the requester being completed
- res_quotient  output  8  quotient result
- res_remainder  output  8  remainder result
- res_dz  output  1  divide-by-zero flag for this result
- res_cycles  output  9  number of cycles spent in WAIT for this result (saturates at 511)
- div_valid  output  1  start pulse to divider
- div_dividend  output  8  dividend operand to divider
- div_divisor  output  8  divisor operand to divider
- div_ready  input  1  divider result pulse, exactly one cycle
- div_quotient  input  8  divider quotient, valid while div_ready is high
- div_remainder  input  8  divider remainder, valid while div_ready is high

Behaviour:
- Reset: asynchronous, active-low.
  - State goes to IDLE and the round-robin pointer to N-1, so requester 0 has first priority.
  - All outputs reset to 0, and all operand, id and result registers clear to 0.
  - Reset is legal in any state, including WAIT. The divider shares rst_n, so no stray div_ready can follow reset.
- Requester contract:
  - Raise req[i] and hold operands stable until done[i] is sampled high.
  - Drop req[i] at the same clock edge that done[i] is sampled. If req[i] is still high in the following IDLE cycle, that is a new request.
- States:
  - IDLE: if any req bit is set, grant the first set bit searching from ptr+1 upward, modulo N.
    - Latch the grant id and that requester's operands.
    - If the latched divisor is 0, go to DONE with quotient 8'hFF, remainder equal to the dividend, and dz=1. The divider is not touched.
    - Otherwise go to ISSUE.
    - If no req bit is set, stay in IDLE.
  - ISSUE: div_valid=1 for exactly this cycle; div_dividend and div_divisor show the latched operands. Clear the cycle counter. Go to WAIT.
  - WAIT: div_valid=0 and the operands stay driven. The cycle counter increments each cycle, saturating at 511.
    - On div_ready=1, capture div_quotient and div_remainder, set dz=0, and go to DONE.
    - There is no timeout.
  - DONE: for one cycle, res_valid=1 and done[id]=1; res_* show the latched values. Set ptr to id. Go to IDLE.
- Output holding:
  - res_* hold their values after DONE until the next DONE.
  - done and res_valid are 0 in every state except DONE.
- Latency, counted from the IDLE cycle in which the grant is taken (cycle 0):
  - Normal path: ISSUE at cycle 1, WAIT from cycle 2, DONE on the cycle after div_ready.
  - Zero-divisor path: DONE at cycle 1.
  - Minimum gap between two grants is 1 IDLE cycle.
- Request timing: a req that rises during ISSUE, WAIT or DONE is only considered at the next IDLE. Requests are never dropped or reordered except by the round-robin rule.
- Fairness: a requester still requesting is served within N grants.
- Protocol checks (assertion only, not corrected in RTL):
  - div_ready asserted outside WAIT is a protocol error.
  - req[i] falling before done[i] is a protocol error.
- Widths: all arithmetic is 8-bit unsigned. res_cycles is 9-bit.

Decomposition:
- Shared package divmod_pkg holds:
  - state encoding constants: IDLE=0, ISSUE=1, WAIT=2, DONE=3
  - DZ_QUOTIENT = 8'hFF
  - CYC_W = 9
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req[N], ptr[IDW].
  - Outputs: any, gnt_id[IDW].
  - Reusable by other shared-resource arbiters.
- Operand muxing, the FSM and the result registers stay in divmod_arbiter.

Test Plan:
- Single requester, req0 with 100/7: exactly one div_valid pulse with div_dividend=100 and div_divisor=7; then done[0] and res_valid with quotient 14, remainder 2, dz=0, res_id=0.
- Divide by zero, req2 with 55/0: DONE one cycle after grant with quotient 8'hFF, remainder 55, dz=1, res_id=2; div_valid never asserts.
- All four requesters raised together with distinct operands: service order 0,1,2,3. req0 re-raised immediately after its done is served after 3, and every result matches a golden div/mod model.
- Last grant 2, then req1 and req3 pending: 3 is served before 1, confirming wrap-around from ptr+1.
- rst_n pulsed low during WAIT: all outputs are 0 immediately (asynchronously). After release, the next grant goes to the lowest pending id and no done pulse is issued for the aborted request.
- Back-to-back on a single requester, req1 with 200/3 then 9/9: results 66 r2, then 1 r0. res_cycles equals the number of WAIT cycles measured by the bench, and one IDLE cycle separates the two grants.
